// File: rtl/zhadan_matrix_ctrl_pkg.sv
// Shared definitions for the bomb/fuse LED matrix driver: FSM state codes
// and the column masks that draw the fuse and the bomb body.
package zhadan_matrix_ctrl_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_BURN = 3'd1;
  localparam logic [2:0] ST_HOLD = 3'd2;
  localparam logic [2:0] ST_SAFE = 3'd3;
  localparam logic [2:0] ST_FAIL = 3'd4;

  localparam int MAX_COLS = 64;

  // Inner pair of columns: the fuse and the top/bottom of the body ring.
  function automatic logic [MAX_COLS-1:0] col_mask_a(input int cols);
    return MAX_COLS'(3) << (cols / 2 - 1);
  endfunction

  // Pair just outside the inner pair: the sides of the body ring.
  function automatic logic [MAX_COLS-1:0] col_mask_b(input int cols);
    return (MAX_COLS'(1) << (cols / 2 - 2)) | (MAX_COLS'(1) << (cols / 2 + 1));
  endfunction

endpackage

// File: rtl/zhadan_matrix_ctrl_tick_gen.sv
// Enabled modulo-DIV divider: emits a one-cycle tick on every DIV-th enabled
// cycle. clr parks the count at zero.
module zhadan_tick_gen #(
  parameter int DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/zhadan_matrix_ctrl.sv
// Bicolour LED matrix driver drawing a bomb whose fuse burns down row by row,
// with pause, defuse, fail flash and a burnt-row count.
module zhadan_matrix_ctrl
  import zhadan_matrix_ctrl_pkg::*;
#(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int FUSE_ROWS = 4,
  parameter int TICK_DIV  = 100,
  parameter int BLINK_DIV = 50
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             BombSwitch,
  input  logic                             start,
  input  logic                             defuse,
  output logic [ROWS-1:0]                  hang,
  output logic [COLS-1:0]                  red,
  output logic [COLS-1:0]                  gre,
  output logic                             fail,
  output logic                             defused,
  output logic [$clog2(FUSE_ROWS+1)-1:0]   burnt
);

  localparam int RW = $clog2(ROWS);
  localparam int BW = $clog2(FUSE_ROWS + 1);
  localparam logic [MAX_COLS-1:0] MASK_A_W = col_mask_a(COLS);
  localparam logic [MAX_COLS-1:0] MASK_B_W = col_mask_b(COLS);
  localparam logic [COLS-1:0] MASK_A     = MASK_A_W[COLS-1:0];
  localparam logic [COLS-1:0] MASK_B     = MASK_B_W[COLS-1:0];
  localparam logic [RW-1:0]   LAST_ROW   = RW'(ROWS - 1);
  localparam logic [RW-1:0]   FUSE_END   = RW'(FUSE_ROWS);
  localparam logic [BW-1:0]   LAST_FUSE  = BW'(FUSE_ROWS - 1);

  logic [RW-1:0]   r;
  logic [2:0]      state;
  logic            blink;
  logic            armed;
  logic            fuse_en, fuse_clr, fuse_tick;
  logic            blink_en, blink_clr, blink_tick;
  logic [ROWS-1:0] row_strobe;
  logic [COLS-1:0] body_mask, img_red, img_gre;

  assign armed = (state == ST_IDLE) || (state == ST_BURN) || (state == ST_HOLD);

  // The cycle that starts or resumes the burn already counts toward the fuse.
  assign fuse_en   = BombSwitch && armed && start && !defuse;
  assign fuse_clr  = !armed;
  assign blink_en  = BombSwitch && (state == ST_FAIL);
  assign blink_clr = (state != ST_FAIL);

  zhadan_tick_gen #(.DIV(TICK_DIV)) u_fuse_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (fuse_en),
    .clr  (fuse_clr),
    .tick (fuse_tick)
  );

  zhadan_tick_gen #(.DIV(BLINK_DIV)) u_blink_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (blink_en),
    .clr  (blink_clr),
    .tick (blink_tick)
  );

  // NOTE: every variable assigned here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    img_red    = '0;
    img_gre    = '0;
    body_mask  = (r == FUSE_END || r == LAST_ROW) ? MASK_A : MASK_B;
    row_strobe = ~({{(ROWS-1){1'b0}}, 1'b1} << (LAST_ROW - r));
    if (int'(r) < FUSE_ROWS) begin
      if (int'(r) >= int'(burnt)) begin
        img_red = MASK_A;
        img_gre = MASK_A;
      end
    end else begin
      case (state)
        ST_SAFE: img_gre = body_mask;
        ST_FAIL: img_red = blink ? body_mask : '0;
        default: img_red = body_mask;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hang    <= '1;
      red     <= '0;
      gre     <= '0;
      fail    <= 1'b0;
      defused <= 1'b0;
      burnt   <= '0;
      r       <= '0;
      blink   <= 1'b0;
      state   <= ST_IDLE;
    end else if (!BombSwitch) begin
      hang <= '1;
      red  <= '0;
      gre  <= '0;
    end else begin
      hang <= row_strobe;
      red  <= img_red;
      gre  <= img_gre;
      r    <= (r == LAST_ROW) ? '0 : r + 1'b1;
      if (blink_tick) blink <= ~blink;
      if (armed) begin
        // Defuse outranks both the final tick and a dropped start.
        if (defuse) begin
          state   <= ST_SAFE;
          defused <= 1'b1;
        end else begin
          if (fuse_tick) burnt <= burnt + 1'b1;
          if (fuse_tick && burnt == LAST_FUSE) begin
            state <= ST_FAIL;
            fail  <= 1'b1;
          end else if (start) begin
            state <= ST_BURN;
          end else if (state == ST_BURN) begin
            state <= ST_HOLD;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_zhadan_matrix_ctrl.sv
// Scoreboard bench for zhadan_matrix_ctrl: a cycle-level game model predicts
// every registered output; a monitor compares after each clock edge.
module tb_zhadan_matrix_ctrl;

  localparam int ROWS      = 8;
  localparam int COLS      = 8;
  localparam int FUSE_ROWS = 4;
  localparam int TICK_DIV  = 4;
  localparam int BLINK_DIV = 2;
  localparam int BW        = $clog2(FUSE_ROWS + 1);

  typedef enum int {P_IDLE, P_BURN, P_HOLD, P_SAFE, P_FAIL} phase_t;

  typedef struct {
    logic [ROWS-1:0] hang;
    logic [COLS-1:0] red;
    logic [COLS-1:0] gre;
    logic            fail;
    logic            defused;
    logic [BW-1:0]   burnt;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            bomb_switch = 1'b0;
  logic            start = 1'b0;
  logic            defuse = 1'b0;
  logic [ROWS-1:0] hang;
  logic [COLS-1:0] red, gre;
  logic            fail, defused;
  logic [BW-1:0]   burnt;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Game model: cumulative burning time and time spent failed, outputs as registers.
  phase_t          m_phase;
  int              m_scan, m_burn_cycles, m_fail_cycles;
  bit              m_fail, m_defused;
  logic [ROWS-1:0] m_hang;
  logic [COLS-1:0] m_red, m_gre;

  always #5 clk = ~clk;

  zhadan_matrix_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .FUSE_ROWS(FUSE_ROWS),
    .TICK_DIV(TICK_DIV), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .BombSwitch (bomb_switch),
    .start      (start),
    .defuse     (defuse),
    .hang       (hang),
    .red        (red),
    .gre        (gre),
    .fail       (fail),
    .defused    (defused),
    .burnt      (burnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void draw(input int row, input int nburnt, input phase_t ph, input bit blk,
                               output logic [COLS-1:0] rd, output logic [COLS-1:0] gr);
    logic [COLS-1:0] inner, outer, body;
    inner = COLS'((1 << (COLS/2 - 1)) | (1 << (COLS/2)));
    outer = COLS'((1 << (COLS/2 - 2)) | (1 << (COLS/2 + 1)));
    rd = '0;
    gr = '0;
    if (row < FUSE_ROWS) begin
      if (row >= nburnt) begin
        rd = inner;
        gr = inner;
      end
    end else begin
      body = (row == FUSE_ROWS || row == ROWS - 1) ? inner : outer;
      if (ph == P_SAFE) gr = body;
      else if (ph == P_FAIL) rd = blk ? body : '0;
      else rd = body;
    end
  endfunction

  function automatic int model_burnt();
    return m_burn_cycles / TICK_DIV;
  endfunction

  task automatic model_step(input bit bs, input bit st, input bit df, input bit rs);
    if (rs) begin
      m_phase = P_IDLE; m_scan = 0; m_burn_cycles = 0; m_fail_cycles = 0;
      m_fail = 0; m_defused = 0;
      m_hang = '1; m_red = '0; m_gre = '0;
    end else if (!bs) begin
      m_hang = '1; m_red = '0; m_gre = '0;
    end else begin
      m_hang = '1;
      m_hang[ROWS - 1 - m_scan] = 1'b0;
      draw(m_scan, model_burnt(), m_phase, ((m_fail_cycles / BLINK_DIV) % 2) == 1, m_red, m_gre);
      m_scan = (m_scan + 1) % ROWS;
      if (m_phase == P_IDLE || m_phase == P_BURN || m_phase == P_HOLD) begin
        if (df) begin
          m_phase = P_SAFE;
          m_defused = 1;
        end else if (st) begin
          m_burn_cycles++;
          if (m_burn_cycles == FUSE_ROWS * TICK_DIV) begin
            m_phase = P_FAIL;
            m_fail = 1;
          end else begin
            m_phase = P_BURN;
          end
        end else if (m_phase == P_BURN) begin
          m_phase = P_HOLD;
        end
      end else if (m_phase == P_FAIL) begin
        m_fail_cycles++;
      end
    end
  endtask

  task automatic drive(input bit bs, input bit st, input bit df, input bit rs);
    exp_t e;
    @(negedge clk);
    rst = rs; bomb_switch = bs; start = st; defuse = df;
    model_step(bs, st, df, rs);
    e.hang = m_hang; e.red = m_red; e.gre = m_gre;
    e.fail = m_fail; e.defused = m_defused; e.burnt = BW'(model_burnt());
    exp_q.push_back(e);
  endtask

  task automatic run(input int n, input bit bs, input bit st, input bit df);
    for (int i = 0; i < n; i++) drive(bs, st, df, 1'b0);
  endtask

  // Monitor: every edge that has a prediction outstanding is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("hang", 64'(hang), 64'(e.hang));
        check("red", 64'(red), 64'(e.red));
        check("gre", 64'(gre), 64'(e.gre));
        check("fail", 64'(fail), 64'(e.fail));
        check("defused", 64'(defused), 64'(e.defused));
        check("burnt", 64'(burnt), 64'(e.burnt));
        check("fail_defused_exclusive", 64'(fail & defused), 64'(0));
      end
    end
  end

  initial begin
    int budget;
    // Idle image walk after reset.
    drive(1, 0, 0, 1);
    run(10, 1, 0, 0);
    // Full burn to failure, then flashing body.
    run(24, 1, 1, 0);
    // Pause and resume.
    drive(1, 0, 0, 1);
    run(6, 1, 1, 0);
    run(20, 1, 0, 0);
    run(6, 1, 1, 0);
    // Defuse on the cycle that would extinguish the last fuse row.
    drive(1, 0, 0, 1);
    run(15, 1, 1, 0);
    drive(1, 1, 1, 0);
    run(10, 1, 1, 0);
    // Display disabled mid-burn.
    drive(1, 0, 0, 1);
    run(7, 1, 1, 0);
    run(10, 0, 1, 0);
    run(8, 1, 1, 0);
    // Reset out of FAIL; a pulse between edges must be ignored.
    drive(1, 0, 0, 1);
    run(19, 1, 1, 0);
    drive(1, 1, 0, 0);
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    run(2, 1, 0, 0);
    drive(1, 1, 0, 1);
    run(4, 1, 0, 0);
    // Random play.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0);
    end
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() > 0) check("drain_timeout", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
